// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - instruction memory boot loader: byte stream -> 32-bit words, then releases the core
module imem_boot_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int CNT_W     = $clog2(MEM_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [CNT_W-1:0] load_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic [31:0]      fetch_addr,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  output logic             core_run,
  output logic             load_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] words_tgt;
  logic [CNT_W-1:0] words_clamped;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_q;
  logic             last_wr;
  logic [31:0]      wr_addr_q;
  logic [31:0]      word_addr;
  logic             accept;
  logic             start_req;

  always_comb begin
    words_clamped = (load_words > DEPTH_C) ? DEPTH_C : load_words;
    start_req     = load_start && (state != LOAD);
    accept        = byte_valid && byte_ready;
    word_addr     = {{(30 - CNT_W){1'b0}}, word_cnt, 2'b00};
  end

  // last_wr marks the write cycle of the final word; the load stops accepting then
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    core_run   = 1'b0;
    mem_addr   = mem_we ? wr_addr_q : word_addr;
    case (state)
      IDLE: begin
        if (load_start) state_nxt = (words_clamped == '0) ? RUN : LOAD;
      end
      LOAD: begin
        byte_ready = !last_wr;
        if (last_wr) state_nxt = RUN;
      end
      RUN: begin
        core_run = 1'b1;
        mem_addr = fetch_addr;
        if (load_start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      words_tgt <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      last_wr   <= 1'b0;
      wr_addr_q <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_we    <= 1'b0;
      load_done <= (state_nxt == RUN) && (state != RUN);
      if (start_req) begin
        words_tgt <= words_clamped;
        word_cnt  <= '0;
        byte_cnt  <= '0;
        // a zero-word reload from RUN passes through LOAD for one cycle only
        last_wr   <= (state == RUN) && (words_clamped == '0);
      end else if (state == LOAD) begin
        if (last_wr) begin
          last_wr <= 1'b0;
        end else if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_q    <= {byte_data, asm_q[23:8]};
          if (byte_cnt == 2'd3) begin
            mem_we    <= 1'b1;
            mem_wdata <= {byte_data, asm_q};
            wr_addr_q <= word_addr;
            if (word_cnt != LAST_IDX) word_cnt <= word_cnt + ONE;
            if (word_cnt == words_tgt - ONE) last_wr <= 1'b1;
          end
        end
      end
    end
  end

endmodule
